// File: rtl/vad_buf_pkg.sv
// vad_buf_pkg: shared state encoding, pointer width and modulo pointer helpers
// for the VAD capture buffer.
package vad_buf_pkg;

   localparam int PTR_W = 12;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } vad_state_e;

   function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] a,
                                                input logic [PTR_W-1:0] b);
      return a + b;
   endfunction

   function automatic logic [PTR_W-1:0] ptr_sub(input logic [PTR_W-1:0] a,
                                                input logic [PTR_W-1:0] b);
      return a - b;
   endfunction

endpackage

// File: rtl/vad_ring_ram.sv
// vad_ring_ram: simple dual-port sample store, one write port and one
// registered read port; the array has no reset so it maps onto block RAM.
module vad_ring_ram
   import vad_buf_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = PTR_W
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_r [0:(1 << ADDR_W) - 1];

   // Write port and one-cycle-latency read port
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem_r[rd_addr];
      end
   end

endmodule

// File: rtl/vad_capture_buffer.sv
// vad_capture_buffer: ring-buffers every audio sample and, on a VAD trigger, streams
// the pre-trigger history plus utterance out. Define VAD_CAPTURE_LEN_EN for utt_len.
module vad_capture_buffer
   import vad_buf_pkg::*;
#(
   parameter int DATA_W              = 16,
   parameter int DEPTH               = 4096,
   parameter int ADDR_W              = PTR_W,
   parameter int PRE_TRIGGER_SAMPLES = 3200
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] audio_in,
   input  logic              sample_valid,
   input  logic              recording_active,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              utt_end,
   output logic              overflow,
   input  logic              overflow_clr,
   output logic [ADDR_W:0]   fill_level,
   output logic [31:0]       utt_len
);

   localparam logic [ADDR_W:0]   FILL_ZERO = (ADDR_W+1)'(0);
   localparam logic [ADDR_W:0]   FILL_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   FILL_PRE  = (ADDR_W+1)'(PRE_TRIGGER_SAMPLES);
   localparam logic [ADDR_W:0]   FILL_FULL = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] PTR_PRE   = ADDR_W'(PRE_TRIGGER_SAMPLES);

   vad_state_e        state_r, state_n_s;
   logic [ADDR_W-1:0] wr_ptr_r, wr_ptr_n_s;
   logic [ADDR_W-1:0] rd_ptr_r, rd_ptr_n_s;
   logic [ADDR_W-1:0] end_ptr_r, end_ptr_n_s;
   logic [ADDR_W:0]   fill_r, fill_n_s;
   logic              rec_d_r;
   logic              inflight_r;
   logic              skid_valid_r, skid_valid_n_s;
   logic [DATA_W-1:0] skid_data_r, skid_data_n_s;
   logic              out_valid_r, out_valid_n_s;
   logic [DATA_W-1:0] out_data_r, out_data_n_s;
   logic              utt_end_r;
   logic              overflow_r, overflow_n_s;
   logic [DATA_W-1:0] ram_q_s;

   logic              accept_s, rise_s, fall_s, at_end_s, room_s;
   logic              pop_s, done_s, drop_s;
   logic [1:0]        slots_s;

   vad_ring_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (sample_valid),
      .wr_addr (wr_ptr_r),
      .wr_data (audio_in),
      .rd_en   (pop_s),
      .rd_addr (rd_ptr_r),
      .rd_data (ram_q_s)
   );

   // Handshake, edge detection and pop/completion decisions
   always_comb begin
      accept_s = out_valid_r & out_ready;
      rise_s   = recording_active & ~rec_d_r;
      fall_s   = ~recording_active & rec_d_r;
      at_end_s = (rd_ptr_r == end_ptr_r);
      // Output slot plus skid plus the read in flight must leave room for one more
      slots_s  = {1'b0, out_valid_r} + {1'b0, skid_valid_r} + {1'b0, inflight_r} - {1'b0, accept_s};
      room_s   = (slots_s < 2'd2);
      pop_s    = 1'b0;
      case (state_r)
         STREAM:  pop_s = room_s & (fill_r != FILL_ZERO);
         DRAIN:   pop_s = room_s & (fill_r != FILL_ZERO) & ~at_end_s;
         default: pop_s = 1'b0;
      endcase
      done_s = (state_r == DRAIN) & at_end_s & ~inflight_r & ~skid_valid_r &
               (~out_valid_r | accept_s) & ~rise_s;
      drop_s = (state_r != IDLE) & sample_valid & ~pop_s & (fill_r == FILL_FULL);
   end

   // Next-state logic
   always_comb begin
      state_n_s = state_r;
      case (state_r)
         IDLE: begin
            if (rise_s) state_n_s = STREAM;
            else        state_n_s = IDLE;
         end
         STREAM: begin
            if (fall_s) state_n_s = DRAIN;
            else        state_n_s = STREAM;
         end
         DRAIN: begin
            if (rise_s)      state_n_s = STREAM;
            else if (done_s) state_n_s = IDLE;
            else             state_n_s = DRAIN;
         end
         default: state_n_s = IDLE;
      endcase
   end

   // Pointer, fill and overflow bookkeeping
   always_comb begin
      wr_ptr_n_s = sample_valid ? ptr_add(wr_ptr_r, PTR_ONE) : wr_ptr_r;
      rd_ptr_n_s = pop_s ? ptr_add(rd_ptr_r, PTR_ONE) : rd_ptr_r;
      if (sample_valid & ~pop_s)      fill_n_s = fill_r + FILL_ONE;
      else if (~sample_valid & pop_s) fill_n_s = fill_r - FILL_ONE;
      else                            fill_n_s = fill_r;
      // Full ring: the new sample displaces the oldest unread one
      if (drop_s) begin
         rd_ptr_n_s = ptr_add(rd_ptr_r, PTR_ONE);
         fill_n_s   = FILL_FULL;
      end else begin
         rd_ptr_n_s = rd_ptr_n_s;
      end
      end_ptr_n_s = end_ptr_r;
      if ((state_r == STREAM) & fall_s)                 end_ptr_n_s = wr_ptr_r;
      else if (drop_s & (state_r == DRAIN) & at_end_s)  end_ptr_n_s = ptr_add(end_ptr_r, PTR_ONE);
      else                                              end_ptr_n_s = end_ptr_r;
      // Outside an utterance only the pre-trigger window is retained
      if (((state_r == IDLE) | done_s) & (fill_n_s > FILL_PRE)) begin
         rd_ptr_n_s = ptr_sub(wr_ptr_n_s, PTR_PRE);
         fill_n_s   = FILL_PRE;
      end else begin
         fill_n_s   = fill_n_s;
      end
      if (drop_s)            overflow_n_s = 1'b1;
      else if (overflow_clr) overflow_n_s = 1'b0;
      else                   overflow_n_s = overflow_r;
   end

   // Two-entry output queue: out register at the head, skid behind it
   always_comb begin
      out_valid_n_s  = out_valid_r;
      out_data_n_s   = out_data_r;
      skid_valid_n_s = skid_valid_r;
      skid_data_n_s  = skid_data_r;
      if (accept_s) begin
         out_valid_n_s  = skid_valid_r;
         out_data_n_s   = skid_valid_r ? skid_data_r : out_data_r;
         skid_valid_n_s = 1'b0;
      end else begin
         out_valid_n_s  = out_valid_r;
      end
      if (inflight_r & ~out_valid_n_s) begin
         out_valid_n_s = 1'b1;
         out_data_n_s  = ram_q_s;
      end else if (inflight_r) begin
         skid_valid_n_s = 1'b1;
         skid_data_n_s  = ram_q_s;
      end else begin
         skid_data_n_s  = skid_data_n_s;
      end
   end

   // State, pointer and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         wr_ptr_r     <= {ADDR_W{1'b0}};
         rd_ptr_r     <= {ADDR_W{1'b0}};
         end_ptr_r    <= {ADDR_W{1'b0}};
         fill_r       <= FILL_ZERO;
         rec_d_r      <= 1'b0;
         inflight_r   <= 1'b0;
         skid_valid_r <= 1'b0;
         skid_data_r  <= {DATA_W{1'b0}};
         out_valid_r  <= 1'b0;
         out_data_r   <= {DATA_W{1'b0}};
         utt_end_r    <= 1'b0;
         overflow_r   <= 1'b0;
      end else begin
         state_r      <= state_n_s;
         wr_ptr_r     <= wr_ptr_n_s;
         rd_ptr_r     <= rd_ptr_n_s;
         end_ptr_r    <= end_ptr_n_s;
         fill_r       <= fill_n_s;
         rec_d_r      <= recording_active;
         inflight_r   <= pop_s;
         skid_valid_r <= skid_valid_n_s;
         skid_data_r  <= skid_data_n_s;
         out_valid_r  <= out_valid_n_s;
         out_data_r   <= out_data_n_s;
         utt_end_r    <= done_s;
         overflow_r   <= overflow_n_s;
      end
   end

`ifdef VAD_CAPTURE_LEN_EN
   logic [31:0] len_cnt_r;
   logic [31:0] utt_len_r;

   // Per-utterance transfer counter, published when the utterance completes
   always_ff @(posedge clk) begin
      if (rst) begin
         len_cnt_r <= 32'd0;
         utt_len_r <= 32'd0;
      end else if (done_s) begin
         len_cnt_r <= 32'd0;
         utt_len_r <= len_cnt_r + {31'd0, accept_s};
      end else begin
         len_cnt_r <= len_cnt_r + {31'd0, accept_s};
         utt_len_r <= utt_len_r;
      end
   end

   assign utt_len = utt_len_r;
`else
   assign utt_len = 32'd0;
`endif

   assign out_data   = out_data_r;
   assign out_valid  = out_valid_r;
   assign utt_end    = utt_end_r;
   assign overflow   = overflow_r;
   assign fill_level = fill_r;

endmodule

// File: tb/tb_vad_capture_buffer.sv
// tb_vad_capture_buffer: randomized stimulus against a sample-index reference model
// of the capture buffer, plus literal checks of the key scenarios.
module tb_vad_capture_buffer;

   localparam int DEPTH = 4096;
   localparam int PRE   = 3200;
`ifdef VAD_CAPTURE_LEN_EN
   localparam bit LEN_EN = 1'b1;
`else
   localparam bit LEN_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] audio_in = 16'd0;
   logic        sample_valid = 1'b0;
   logic        recording_active = 1'b0;
   logic        out_ready = 1'b0;
   logic        overflow_clr = 1'b0;
   logic [15:0] out_data;
   logic        out_valid;
   logic        utt_end;
   logic        overflow;
   logic [12:0] fill_level;
   logic [31:0] utt_len;

   always #5 clk = ~clk;

   vad_capture_buffer dut (
      .clk              (clk),
      .rst              (rst),
      .audio_in         (audio_in),
      .sample_valid     (sample_valid),
      .recording_active (recording_active),
      .out_data         (out_data),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .utt_end          (utt_end),
      .overflow         (overflow),
      .overflow_clr     (overflow_clr),
      .fill_level       (fill_level),
      .utt_len          (utt_len)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (absolute sample indices) ----------------
   logic [15:0] hist[int];
   logic [15:0] m_q[$];
   int   m_mode = 0;            // 0 idle, 1 recording, 2 finishing
   int   m_wr = 0, m_rd = 0, m_end = 0;
   int   m_len = 0, m_ulen = 0;
   bit   m_rec_d = 0, m_infl = 0, m_ovf = 0, m_uend = 0;
   logic [15:0] m_infl_val = 16'd0;

   always @(posedge clk) begin : model
      int acc, fill, pop, done, rise, fall;
      if (rst) begin
         hist.delete(); m_q.delete();
         m_mode = 0; m_wr = 0; m_rd = 0; m_end = 0; m_len = 0; m_ulen = 0;
         m_rec_d = 0; m_infl = 0; m_ovf = 0; m_uend = 0;
      end else begin
         acc  = (m_q.size() > 0 && out_ready) ? 1 : 0;
         rise = (recording_active && !m_rec_d) ? 1 : 0;
         fall = (!recording_active && m_rec_d) ? 1 : 0;
         fill = m_wr - m_rd;
         pop  = ((m_mode == 1 || (m_mode == 2 && m_rd != m_end)) && fill > 0 &&
                 (m_q.size() - acc + int'(m_infl)) < 2) ? 1 : 0;
         done = (m_mode == 2 && m_rd == m_end && !m_infl && (m_q.size() - acc) == 0 && !rise) ? 1 : 0;
         if (acc != 0) begin void'(m_q.pop_front()); m_len++; end
         if (m_infl) m_q.push_back(m_infl_val);
         m_infl = (pop != 0);
         if (pop != 0) begin m_infl_val = hist[m_rd]; m_rd++; end
         if (m_mode == 1 && fall != 0) m_end = m_wr;
         if (sample_valid) begin hist[m_wr] = audio_in; m_wr++; end
         if (m_mode != 0 && sample_valid && pop == 0 && fill == DEPTH - 1) begin
            if (m_mode == 2 && m_rd == m_end) m_end++;
            m_rd++;
            m_ovf = 1;
         end else if (overflow_clr) m_ovf = 0;
         if ((m_mode == 0 || done != 0) && (m_wr - m_rd) > PRE) m_rd = m_wr - PRE;
         m_uend = (done != 0);
         if (done != 0) begin m_ulen = m_len; m_len = 0; end
         if (m_mode == 0 && rise != 0) m_mode = 1;
         else if (m_mode == 1 && fall != 0) m_mode = 2;
         else if (m_mode == 2 && rise != 0) m_mode = 1;
         else if (m_mode == 2 && done != 0) m_mode = 0;
         m_rec_d = recording_active;
      end
   end

   // ---------------- compare process and observation counters ----------------
   int xfer_cnt = 0, uend_cnt = 0, peak = 0;
   bit want_first = 0;
   logic [15:0] first_val = 16'd0;

   always @(negedge clk) begin
      check("fill_level", 64'(fill_level), 64'(m_wr - m_rd));
      check("out_valid", 64'(out_valid), 64'(m_q.size() > 0));
      if (m_q.size() > 0) check("out_data", 64'(out_data), 64'(m_q[0]));
      check("utt_end", 64'(utt_end), 64'(m_uend));
      check("overflow", 64'(overflow), 64'(m_ovf));
      check("utt_len", 64'(utt_len), LEN_EN ? 64'(m_ulen) : 64'd0);
      if (out_valid && out_ready && !rst) begin
         xfer_cnt++;
         if (want_first) begin first_val = out_data; want_first = 0; end
      end
      if (utt_end) uend_cnt++;
      if (int'(fill_level) > peak) peak = int'(fill_level);
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk); #2;
   endtask

   task automatic wait_uend(input int bound, input string name);
      int base = uend_cnt;
      int n = 0;
      while (uend_cnt == base && n < bound) begin tick(); n++; end
      check(name, 64'(uend_cnt > base), 64'd1);
   endtask

   task automatic wait_first(input int bound, input string name);
      int n = 0;
      while (want_first && n < bound) begin tick(); n++; end
      check(name, 64'(want_first), 64'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1; sample_valid = 1'b0; recording_active = 1'b0;
      out_ready = 1'b0; overflow_clr = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   initial begin
      int base, ucnt, n;
      logic [15:0] first_audio;

      do_reset();
      check("rst_fill", 64'(fill_level), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);
      check("rst_utt_len", 64'(utt_len), 64'd0);

      // Ramp of 5000, then trigger: history must start at 1800
      peak = 0;
      for (int i = 0; i < 5000; i++) begin
         sample_valid = 1'b1; audio_in = 16'(i); tick();
      end
      sample_valid = 1'b0;
      check("ramp_fill_sat", 64'(fill_level), 64'd3200);
      want_first = 1; out_ready = 1'b1; recording_active = 1'b1;
      wait_first(20, "ramp_first_timeout");
      check("ramp_first_data", 64'(first_val), 64'd1800);
      check("ramp_peak", 64'(peak), 64'd3200);
      for (int i = 0; i < 200; i++) begin
         sample_valid = 1'($urandom_range(0, 1)); audio_in = 16'($urandom); tick();
      end
      sample_valid = 1'b0; recording_active = 1'b0;
      wait_uend(8000, "ramp_uend_timeout");

      // Early trigger: partial history starting at sample 0
      do_reset();
      for (int i = 0; i < 100; i++) begin
         sample_valid = 1'b1; audio_in = 16'(i); tick();
      end
      sample_valid = 1'b0;
      check("partial_fill", 64'(fill_level), 64'd100);
      want_first = 1; out_ready = 1'b1; recording_active = 1'b1;
      wait_first(20, "partial_first_timeout");
      check("partial_first_data", 64'(first_val), 64'd0);
      repeat (150) tick();
      recording_active = 1'b0;
      wait_uend(50, "partial_uend_timeout");
      check("partial_utt_len", 64'(utt_len), LEN_EN ? 64'd100 : 64'd0);

      // Stalled consumer: frozen output and overflow
      do_reset();
      first_audio = 16'($urandom);
      recording_active = 1'b1; sample_valid = 1'b1; audio_in = first_audio; tick();
      for (int i = 0; i < 4300; i++) begin
         audio_in = 16'($urandom);
         overflow_clr = ($urandom_range(0, 7) == 0);
         tick();
      end
      overflow_clr = 1'b0;
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_out_data", 64'(out_data), 64'(first_audio));
      check("stall_overflow", 64'(overflow), 64'd1);
      check("stall_fill", 64'(fill_level), 64'd4095);
      sample_valid = 1'b0; overflow_clr = 1'b1; tick();
      overflow_clr = 1'b0;
      check("ovf_clr", 64'(overflow), 64'd0);
      out_ready = 1'b1; recording_active = 1'b0;
      wait_uend(10000, "stall_uend_timeout");

      // Random throttled utterance, drop after 1000 transfers
      do_reset();
      for (int i = 0; i < 300; i++) begin
         sample_valid = 1'($urandom_range(0, 1)); audio_in = 16'($urandom); tick();
      end
      base = xfer_cnt; ucnt = uend_cnt; n = 0;
      recording_active = 1'b1;
      while (xfer_cnt - base < 1000 && n < 10000) begin
         sample_valid = 1'($urandom_range(0, 1)); audio_in = 16'($urandom);
         out_ready = 1'($urandom_range(0, 1)); tick(); n++;
      end
      check("rand_stream_timeout", 64'(xfer_cnt - base >= 1000), 64'd1);
      recording_active = 1'b0; n = 0;
      while (uend_cnt == ucnt && n < 20000) begin
         sample_valid = 1'($urandom_range(0, 1)); audio_in = 16'($urandom);
         out_ready = 1'($urandom_range(0, 1)); tick(); n++;
      end
      repeat (3) tick();
      check("rand_uend_pulses", 64'(uend_cnt - ucnt), 64'd1);
      check("rand_utt_len", 64'(utt_len), LEN_EN ? 64'(xfer_cnt - base) : 64'd0);

      // Re-trigger during drain merges utterances
      do_reset();
      base = xfer_cnt; ucnt = uend_cnt;
      recording_active = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         sample_valid = 1'b1; audio_in = 16'($urandom); tick();
      end
      out_ready = 1'b0;
      for (int i = 0; i < 60; i++) begin
         sample_valid = 1'b1; audio_in = 16'($urandom); tick();
      end
      recording_active = 1'b0;
      for (int i = 0; i < 10; i++) begin
         sample_valid = 1'($urandom_range(0, 1)); audio_in = 16'($urandom);
         out_ready = 1'($urandom_range(0, 1)); tick();
      end
      recording_active = 1'b1;
      for (int i = 0; i < 100; i++) begin
         sample_valid = 1'($urandom_range(0, 1)); audio_in = 16'($urandom);
         out_ready = 1'($urandom_range(0, 1)); tick();
      end
      check("merge_no_uend", 64'(uend_cnt - ucnt), 64'd0);
      sample_valid = 1'b0; out_ready = 1'b1; recording_active = 1'b0;
      wait_uend(2000, "merge_uend_timeout");
      repeat (3) tick();
      check("merge_uend_pulses", 64'(uend_cnt - ucnt), 64'd1);
      check("merge_utt_len", 64'(utt_len), LEN_EN ? 64'(xfer_cnt - base) : 64'd0);

      // Reset in the middle of streaming
      recording_active = 1'b1; out_ready = 1'b0;
      for (int i = 0; i < 50; i++) begin
         sample_valid = 1'b1; audio_in = 16'($urandom | 32'h1); tick();
      end
      rst = 1'b1; tick();
      check("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check("mid_rst_out_data", 64'(out_data), 64'd0);
      check("mid_rst_fill", 64'(fill_level), 64'd0);
      check("mid_rst_utt_end", 64'(utt_end), 64'd0);
      check("mid_rst_overflow", 64'(overflow), 64'd0);
      check("mid_rst_utt_len", 64'(utt_len), 64'd0);
      rst = 1'b0; sample_valid = 1'b0; recording_active = 1'b0;
      repeat (5) tick();
      check("post_rst_fill", 64'(fill_level), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
